// File: rtl/mem_crc_pkg.sv
// mem_crc_pkg: constants and types shared by the CRC checker and the write-side encoder.
// Word layout: payload in bits [11:4], CRC-4 (x^4+x+1) in bits [3:0].
package mem_crc_pkg;

   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned CRC_W     = 4;
   localparam int unsigned WORD_W    = 12;
   localparam int unsigned BIT_CNT_W = 3;
   localparam int unsigned ERR_CNT_W = 8;

   // Generator x^4+x+1; the x^4 term is implicit.
   localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_CALC  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // One memory word as presented by the read port.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [CRC_W-1:0]  crc;
   } mem_word_t;

endpackage

// File: rtl/mem_crc_checker_if.sv
// mem_crc_checker_if: request/response bus plus memory read port of the CRC checker.
//   rd_req/rd_addr/rd_ready      : read request handshake
//   mem_read_addr/mem_read_data  : registered address out, combinational word back
//   out_valid/out_data/crc_err   : checked result
//   scrub_en/err_count/last_err_addr : background scrubber, only with CRC_CHK_SCRUB_EN
// slave = checker side, master = requester/memory side.
interface mem_crc_checker_if;
   import mem_crc_pkg::*;

   logic                 rd_req;
   logic [ADDR_W-1:0]    rd_addr;
   logic                 rd_ready;
   logic [ADDR_W-1:0]    mem_read_addr;
   logic [WORD_W-1:0]    mem_read_data;
   logic                 out_valid;
   logic [DATA_W-1:0]    out_data;
   logic                 crc_err;
`ifdef CRC_CHK_SCRUB_EN
   logic                 scrub_en;
   logic [ERR_CNT_W-1:0] err_count;
   logic [ADDR_W-1:0]    last_err_addr;
`endif

   modport slave (
      input  rd_req, rd_addr, mem_read_data,
`ifdef CRC_CHK_SCRUB_EN
      input  scrub_en,
      output err_count, last_err_addr,
`endif
      output rd_ready, mem_read_addr, out_valid, out_data, crc_err
   );

   modport master (
      output rd_req, rd_addr, mem_read_data,
`ifdef CRC_CHK_SCRUB_EN
      output scrub_en,
      input  err_count, last_err_addr,
`endif
      input  rd_ready, mem_read_addr, out_valid, out_data, crc_err
   );

endinterface

// File: rtl/crc4_lfsr_step.sv
// crc4_lfsr_step: one bit-serial CRC-4 LFSR update, MSB-first data.
//   crc_in     : current CRC
//   din        : next data bit
//   crc_next_c : combinational updated CRC
module crc4_lfsr_step
   import mem_crc_pkg::*;
(
   input  logic [CRC_W-1:0] crc_in,
   input  logic             din,
   output logic [CRC_W-1:0] crc_next_c
);

   logic fb;

   always_comb begin
      fb         = crc_in[CRC_W-1] ^ din;
      crc_next_c = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_W'(0));
   end

endmodule

// File: rtl/mem_crc_checker.sv
// mem_crc_checker: read-side CRC checker for the 16x12 protected memory.
// Accepts a read, fetches the word, recomputes CRC-4 over the payload one bit
// per cycle and returns payload + crc_err 10 cycles after acceptance.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mem_crc_checker_if.slave (request, memory port, result)
// Optional feature macro: CRC_CHK_SCRUB_EN adds a background scrubber that
// walks all addresses while idle and logs error count / last failing address.
module mem_crc_checker
   import mem_crc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   mem_crc_checker_if.slave   bus
);

   state_e              state;
   state_e              state_nxt;
   logic                accept_c;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   data_sr;
   logic [CRC_W-1:0]    stored_crc;
   logic [CRC_W-1:0]    crc_q;
   logic [CRC_W-1:0]    crc_step;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic                rd_ready_q;
   logic                out_valid_q;
   logic [DATA_W-1:0]   out_data_q;
   logic                crc_err_q;
   mem_word_t           word_c;
`ifdef CRC_CHK_SCRUB_EN
   logic                scrub_start_c;
   logic                scrub_q;
   logic [ADDR_W-1:0]   scrub_addr;
   logic [ERR_CNT_W-1:0] err_count_q;
   logic [ADDR_W-1:0]   last_err_addr_q;
`endif

   assign word_c            = mem_word_t'(bus.mem_read_data);
   assign bus.rd_ready      = rd_ready_q;
   assign bus.mem_read_addr = addr_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.crc_err       = crc_err_q;
`ifdef CRC_CHK_SCRUB_EN
   assign bus.err_count     = err_count_q;
   assign bus.last_err_addr = last_err_addr_q;
`endif

   // Single-bit LFSR update fed from the MSB of the payload shift register.
   crc4_lfsr_step u_step (
      .crc_in     (crc_q),
      .din        (data_sr[DATA_W-1]),
      .crc_next_c (crc_step)
   );

   // Next-state logic; rd_req wins over the scrubber in IDLE.
   always_comb begin
      state_nxt     = state;
      accept_c      = 1'b0;
`ifdef CRC_CHK_SCRUB_EN
      scrub_start_c = 1'b0;
`endif
      unique case (state)
         ST_IDLE: begin
            if (bus.rd_req && rd_ready_q) begin
               accept_c  = 1'b1;
               state_nxt = ST_FETCH;
            end
`ifdef CRC_CHK_SCRUB_EN
            else if (bus.scrub_en) begin
               scrub_start_c = 1'b1;
               state_nxt     = ST_FETCH;
            end
`endif
         end
         ST_FETCH: state_nxt = ST_CALC;
         ST_CALC: begin
            if (bit_cnt == BIT_CNT_W'(DATA_W-1)) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register and datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         data_sr     <= '0;
         stored_crc  <= '0;
         crc_q       <= '0;
         bit_cnt     <= '0;
         rd_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         crc_err_q   <= 1'b0;
`ifdef CRC_CHK_SCRUB_EN
         scrub_q         <= 1'b0;
         scrub_addr      <= '0;
         err_count_q     <= '0;
         last_err_addr_q <= '0;
`endif
      end else begin
         state      <= state_nxt;
         rd_ready_q <= (state_nxt == ST_IDLE);
`ifdef CRC_CHK_SCRUB_EN
         out_valid_q <= (state_nxt == ST_DONE) && !scrub_q;
`else
         out_valid_q <= (state_nxt == ST_DONE);
`endif
         unique case (state)
            ST_IDLE: begin
               if (accept_c) begin
                  addr_q <= bus.rd_addr;
`ifdef CRC_CHK_SCRUB_EN
                  scrub_q <= 1'b0;
`endif
               end
`ifdef CRC_CHK_SCRUB_EN
               else if (scrub_start_c) begin
                  addr_q  <= scrub_addr;
                  scrub_q <= 1'b1;
               end
`endif
            end
            ST_FETCH: begin
               // Captures whatever the port shows, including forwarded writes.
               data_q     <= word_c.data;
               data_sr    <= word_c.data;
               stored_crc <= word_c.crc;
               crc_q      <= '0;
               bit_cnt    <= '0;
            end
            ST_CALC: begin
               crc_q   <= crc_step;
               data_sr <= {data_sr[DATA_W-2:0], 1'b0};
               bit_cnt <= BIT_CNT_W'(bit_cnt + 1'b1);
               // Last bit: crc_step already holds the final CRC.
               if (bit_cnt == BIT_CNT_W'(DATA_W-1)) begin
`ifdef CRC_CHK_SCRUB_EN
                  if (scrub_q) begin
                     scrub_addr <= ADDR_W'(scrub_addr + 1'b1);
                     if (crc_step != stored_crc) begin
                        last_err_addr_q <= addr_q;
                        if (err_count_q != {ERR_CNT_W{1'b1}})
                           err_count_q <= ERR_CNT_W'(err_count_q + 1'b1);
                     end
                  end else begin
                     out_data_q <= data_q;
                     crc_err_q  <= (crc_step != stored_crc);
                  end
`else
                  out_data_q <= data_q;
                  crc_err_q  <= (crc_step != stored_crc);
`endif
               end
            end
            ST_DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_crc_checker.sv
// tb_mem_crc_checker: scoreboard bench for mem_crc_checker with a 16x12 memory
// model that forwards same-cycle writes to the read port.
// Scrubber checks run when CRC_CHK_SCRUB_EN is defined.
module tb_mem_crc_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   logic [11:0] mem [16];
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [11:0] wr_data = '0;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         due;
   } exp_t;
   exp_t exp_q[$];

   mem_crc_checker_if bus();

   mem_crc_checker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory: synchronous write, combinational read with same-address forwarding.
   always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
   always_comb begin
      if (wr_en && wr_addr == bus.mem_read_addr) bus.mem_read_data = wr_data;
      else                                       bus.mem_read_data = mem[bus.mem_read_addr];
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every out_valid pulse is matched against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
         check("ready_valid_exclusive", int'(bus.rd_ready), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", int'(bus.out_valid), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", int'(bus.out_data), int'(e.data));
            check("crc_err", int'(bus.crc_err), int'(e.err));
            check("latency", cyc, e.due);
         end
      end
   end

   // Called #1 after a posedge; returns #1 after the write edge.
   task automatic write_word(input logic [3:0] a, input logic [11:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Called #1 after a posedge; holds rd_req until accepted, returns #1 after the accept edge.
   task automatic issue(input logic [3:0] a, input logic [7:0] ed, input logic ee,
                        input bit expect_out, output int acc);
      int  waited;
      bit  ok;
      exp_t e;
      waited = 0; ok = 0; acc = -1;
      bus.rd_req = 1'b1; bus.rd_addr = a;
      while (!ok && waited < 50) begin
         @(negedge clk);
         if (bus.rd_ready) begin
            @(posedge clk); #1;
            acc = cyc; ok = 1;
         end else waited++;
      end
      bus.rd_req = 1'b0;
      if (!ok) check("accept_timeout", waited, 0);
      else if (expect_out) begin
         e.data = ed; e.err = ee; e.due = acc + 9;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int a1, a2;
      bus.rd_req  = 1'b0;
      bus.rd_addr = '0;
`ifdef CRC_CHK_SCRUB_EN
      bus.scrub_en = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("reset_rd_ready", int'(bus.rd_ready), 1);
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_out_data", int'(bus.out_data), 0);
      check("reset_crc_err", int'(bus.crc_err), 0);
      check("reset_mem_read_addr", int'(bus.mem_read_addr), 0);

      // Good word 0x80E: CRC of 0x80 is 0xE.
      write_word(4'd5, 12'h80E);
      issue(4'd5, 8'h80, 1'b0, 1'b1, a1);
      check("busy_rd_ready", int'(bus.rd_ready), 0);
      idle_cycles(14);
      check("hold_out_data", int'(bus.out_data), 8'h80);
      check("hold_crc_err", int'(bus.crc_err), 0);

      // Corrupted CRC nibble.
      write_word(4'd5, 12'h80F);
      issue(4'd5, 8'h80, 1'b1, 1'b1, a1);
      idle_cycles(12);

      // Back-to-back: the second request is held while busy and taken at N+11.
      write_word(4'd0, 12'h013);
      write_word(4'd15, 12'h000);
      issue(4'd0, 8'h01, 1'b0, 1'b1, a1);
      issue(4'd15, 8'h00, 1'b0, 1'b1, a2);
      check("accept_gap", a2 - a1, 11);
      idle_cycles(12);

      // Write forwarded during FETCH replaces a good stored word.
      write_word(4'd3, 12'h80E);
      issue(4'd3, 8'h80, 1'b1, 1'b1, a1);
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 12'h80F;
      @(posedge clk); #1;
      wr_en = 1'b0;
      idle_cycles(12);

      // Reset at N+5 aborts the read with no result.
      issue(4'd5, 8'h00, 1'b0, 1'b0, a1);
      check("mem_read_addr_latched", int'(bus.mem_read_addr), 5);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_rd_ready", int'(bus.rd_ready), 1);
      check("abort_mem_read_addr", int'(bus.mem_read_addr), 0);
      idle_cycles(15);

`ifdef CRC_CHK_SCRUB_EN
      for (int i = 0; i < 16; i++)
         write_word(4'(i), (i == 2 || i == 9) ? 12'h001 : 12'h000);
      bus.scrub_en = 1'b1;
      idle_cycles(180);
      bus.scrub_en = 1'b0;
      idle_cycles(15);
      check("scrub_err_count_pass1", int'(bus.err_count), 2);
      check("scrub_last_err_addr", int'(bus.last_err_addr), 9);
      bus.scrub_en = 1'b1;
      idle_cycles(23000);
      bus.scrub_en = 1'b0;
      idle_cycles(15);
      check("scrub_err_count_sat", int'(bus.err_count), 255);
      write_word(4'd5, 12'h80E);
      issue(4'd5, 8'h80, 1'b0, 1'b1, a1);
      idle_cycles(12);
`endif

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_crc_checker.md
# mem_crc_checker

Read-side companion to the team's 16×12 CRC-protected memory. Accepts read requests, drives the memory read address, captures the 12-bit word, recomputes the 4-bit CRC over the 8 data bits with a bit-serial LFSR, and returns the data with a CRC error flag. It sits between the memory's combinational read port and any consumer of checked data.

## Interface
- ADDR_W, 4, memory address width (16 words)
- DATA_W, 8, payload bits per word, stored in word bits [11:4]
- CRC_W, 4, check bits per word, stored in word bits [3:0]
- CRC_POLY, 4'h3, generator x^4+x+1, implicit x^4 term
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  read request; accepted on a cycle where rd_req && rd_ready
- rd_addr  in  ADDR_W  word address, sampled on acceptance
- rd_ready  out  1  checker idle and able to accept
- mem_read_addr  out  ADDR_W  registered address to the memory read port
- mem_read_data  in  DATA_W+CRC_W  combinational read data from memory
- out_valid  out  1  one-cycle pulse: result valid
- out_data  out  DATA_W  captured payload
- crc_err  out  1  recomputed CRC ≠ stored CRC; qualified by out_valid
- scrub_en, err_count[7:0], last_err_addr[ADDR_W-1:0]: present only with CRC_CHK_SCRUB_EN (see Configuration)

## Operation
- FSM: IDLE → FETCH → CALC → DONE → IDLE.
- IDLE: rd_ready=1. On rd_req, latch rd_addr into mem_read_addr and go to FETCH.
- FETCH: capture mem_read_data into data shift register and stored-CRC register. Clear the CRC register to 0. Clear the bit counter.
- CALC: 8 cycles, MSB first. Per bit d: fb = crc[3]^d; crc = {crc[2:0],1'b0} ^ (fb ? CRC_POLY : 0). Bit counter 0..7, exit after count 7.
- DONE: out_valid=1, out_data=captured payload, crc_err=(crc != stored CRC). Return to IDLE.
- rd_req while rd_ready=0 is ignored. The requester holds the request.
- The memory forwards same-cycle writes to the same address. The word captured in FETCH is whatever the port presents that cycle, forwarded data included.
- out_data and crc_err hold their values until the next DONE.
- Reset values: state IDLE, rd_ready=1, mem_read_addr=0, out_valid=0, out_data=0, crc_err=0. Counters and shift registers are 0.
- rst asserted mid-operation: abort at the next edge and return to IDLE. No out_valid is produced for the aborted request.

## Timing
- Accept at edge N. FETCH during N+1. CALC during N+2..N+9. out_valid high during N+10. rd_ready high again at N+11.
- Fixed 10-cycle latency from acceptance to result. Throughput is one request per 11 cycles.
- rd_ready and out_valid are never high in the same cycle.

## Configuration
- CRC_CHK_SCRUB_EN defined:
  - Background scrubber. In IDLE with scrub_en=1 and rd_req=0, start a check on the internal scrub_addr, with the same FETCH/CALC path and rd_ready=0.
  - The scrub result does not raise out_valid.
  - On scrub error: err_count increments, saturating at 255; last_err_addr = scrub_addr.
  - scrub_addr increments after each scrub and wraps 15→0.
  - rd_req has priority when both are pending in IDLE.
  - err_count, last_err_addr and scrub_addr reset to 0.
- Undefined: no scrub logic and no scrub ports. Behaviour is identical to the request-only path.

## Structure
- Shared package mem_crc_pkg:
  - constants ADDR_W, DATA_W, CRC_W, WORD_W=12, CRC_POLY
  - FSM state enum
  - the same constants are used by the CRC encoder on the write side
- One sub-module: crc4_lfsr_step, the single-bit combinational LFSR update, reused by the write-side encoder.

## Test plan
- Reset, then memory word 0x80E at addr 5, rd_req addr 5 → out_valid at N+10, out_data=0x80, crc_err=0.
- Word 0x80F at addr 5 → out_data=0x80, crc_err=1.
- Word 0x013 at addr 0, then 0x000 at addr 15 → both crc_err=0. rd_req during busy is ignored; the second request is accepted at N+11.
- Write 0x80F to addr 3 in the FETCH cycle of a read of addr 3 → forwarded word captured, crc_err=1.
- rst at N+5 → no out_valid, rd_ready=1 and mem_read_addr=0 after the reset edge.
- With CRC_CHK_SCRUB_EN, addrs 2 and 9 corrupted, scrub_en=1 for 200 cycles → err_count=2, last_err_addr=9 after the first pass. err_count saturates at 255 on a long run with corruption present.
